// File: rtl/z80readback.sv
// Z80 I/O read responder for the VGA peripheral.
// The VGA side fills a small FIFO. A Z80 IN from the data port pops one byte.
// A Z80 IN from the status port returns the FIFO flags.
module z80readback #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       read,
  input  logic       iorq,
  input  logic [1:0] chipsel,
  input  logic       addr,
  input  logic       push,
  input  logic [7:0] pushdata,
  output logic       full,
  output logic [4:0] level,
  output logic [7:0] dataout,
  output logic       drive
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {DISARMED, IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0]      read_q, iorq_q, addr_q, fill_q;
  logic [SYNC_STAGES-1:0][1:0] cs_q;
  logic                        read_s, iorq_s, addr_s, rdcyc, armed;
  logic [1:0]                  chipsel_s;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [4:0]    count;
  logic          ovf, udf, empty;
  logic          latch, data_rd, stat_rd, pop, push_ok, ovf_set, udf_set;
  logic [7:0]    status;

  assign read_s    = read_q[SYNC_STAGES-1];
  assign iorq_s    = iorq_q[SYNC_STAGES-1];
  assign addr_s    = addr_q[SYNC_STAGES-1];
  assign chipsel_s = cs_q[SYNC_STAGES-1];
  assign rdcyc     = ~read_s & ~iorq_s & (chipsel_s == 2'b00);
  // The synchronizers reset to "inactive". They only show the real pins once
  // they have filled, so DISARMED ignores them until then. Otherwise a cycle
  // that was already in progress at reset release would be answered.
  assign armed     = fill_q[SYNC_STAGES-1];

  // Synchronize the Z80 control/address inputs and track how far the chain has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q <= '1;
      iorq_q <= '1;
      cs_q   <= '1;
      addr_q <= '0;
      fill_q <= '0;
    end else begin
      read_q <= {read_q[SYNC_STAGES-2:0], read};
      iorq_q <= {iorq_q[SYNC_STAGES-2:0], iorq};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], chipsel};
      addr_q <= {addr_q[SYNC_STAGES-2:0], addr};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_L);
  assign level   = count;
  assign latch   = (state == IDLE) && rdcyc;
  assign data_rd = latch & ~addr_s;
  assign stat_rd = latch & addr_s;
  assign pop     = data_rd & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign udf_set = data_rd & empty;
  assign status  = {~empty, full, ovf, udf, count[3:0]};
  assign drive   = (state == ACTIVE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISARMED;
    else        state <= state_nx;
  end

  // Next-state logic: exactly one access per Z80 read cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      DISARMED: if (armed && !rdcyc) state_nx = IDLE;
      IDLE:     if (rdcyc)           state_nx = ACTIVE;
      ACTIVE:   if (!rdcyc)          state_nx = IDLE;
      default:                       state_nx = DISARMED;
    endcase
  end

  // FIFO storage. It needs no reset because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= pushdata;
  end

  // FIFO pointers, occupancy, sticky flags and the latched response byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      dataout <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      // A set on the same edge as a status read wins over the clear.
      ovf <= ovf_set | (ovf & ~stat_rd);
      udf <= udf_set | (udf & ~stat_rd);
      if (latch) dataout <= addr_s ? status : (empty ? 8'h00 : mem[rptr]);
    end
  end

endmodule
